// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and EX operand forwarding-select generation for a 5-stage pipeline.
// Optional macro HAZARD_WB_BYPASS_EN: WB-stage producers forward through select 3 (regfile not write-through).
module hazard_fwd_unit #(
  parameter int REG_BITS  = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_BITS-1:0]  id_rs,
  input  logic [REG_BITS-1:0]  id_rt,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic [REG_BITS-1:0]  id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 flush,
  output logic                 stall,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] dest;
    logic                reg_write;
    logic                mem_read;
  } stage_rec_t;

  localparam stage_rec_t REC_IDLE = '{
    valid:     1'b0,
    dest:      {REG_BITS{1'b0}},
    reg_write: 1'b0,
    mem_read:  1'b0
  };

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  stage_rec_t ex_r;
  stage_rec_t mem_r;
  stage_rec_t wb_r;
`ifdef HAZARD_WB_BYPASS_EN
  stage_rec_t wb2_r;
`endif

  logic                 stall_s;
  logic [1:0]           fwd_a_nxt_s;
  logic [1:0]           fwd_b_nxt_s;
  logic [1:0]           fwd_a_sel_r;
  logic [1:0]           fwd_b_sel_r;
  logic [CNT_WIDTH-1:0] stall_count_r;
  stage_rec_t           id_rec_s;

  // Register 0 is hardwired, so a record never "writes" it; need_load narrows the match to loads.
  function automatic logic rec_writes(input stage_rec_t rec, input logic [REG_BITS-1:0] r,
                                      input logic need_load);
    rec_writes = rec.valid & rec.reg_write & (rec.dest == r) &
                 (r != {REG_BITS{1'b0}}) & (rec.mem_read | ~need_load);
  endfunction

  // Nearest producer wins: the record now in EX sits in EX/MEM when the consumer reaches EX.
  function automatic logic [1:0] fwd_pick(input logic [REG_BITS-1:0] src, input logic used,
                                          input stage_rec_t ex_rec, input stage_rec_t mem_rec,
                                          input stage_rec_t wb_rec);
    if (!used) begin
      fwd_pick = 2'd0;
    end else if (rec_writes(ex_rec, src, 1'b0)) begin
      fwd_pick = 2'd1;
    end else if (rec_writes(mem_rec, src, 1'b0)) begin
      fwd_pick = 2'd2;
    end else if (rec_writes(wb_rec, src, 1'b0)) begin
`ifdef HAZARD_WB_BYPASS_EN
      fwd_pick = 2'd3;
`else
      fwd_pick = 2'd0;
`endif
    end else begin
      fwd_pick = 2'd0;
    end
  endfunction

  // Load-use detection against the EX record; a flush kills the consumer so no stall is needed.
  always_comb begin
    stall_s = 1'b0;
    if (id_valid && !flush) begin
      stall_s = (id_rs_used & rec_writes(ex_r, id_rs, 1'b1)) |
                (id_rt_used & rec_writes(ex_r, id_rt, 1'b1));
    end else begin
      stall_s = 1'b0;
    end
  end

  // Next-cycle operand selects and the record that enters EX.
  always_comb begin
    fwd_a_nxt_s = 2'd0;
    fwd_b_nxt_s = 2'd0;
    id_rec_s    = REC_IDLE;
    if (id_valid && !flush && !stall_s) begin
      fwd_a_nxt_s = fwd_pick(id_rs, id_rs_used, ex_r, mem_r, wb_r);
      fwd_b_nxt_s = fwd_pick(id_rt, id_rt_used, ex_r, mem_r, wb_r);
      id_rec_s    = '{valid: 1'b1, dest: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
    end else begin
      fwd_a_nxt_s = 2'd0;
      fwd_b_nxt_s = 2'd0;
      id_rec_s    = REC_IDLE;
    end
  end

  // Stage record pipeline; a stall or flush injects a bubble into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r  <= REC_IDLE;
      mem_r <= REC_IDLE;
      wb_r  <= REC_IDLE;
`ifdef HAZARD_WB_BYPASS_EN
      wb2_r <= REC_IDLE;
`endif
    end else begin
      ex_r  <= id_rec_s;
      mem_r <= ex_r;
      wb_r  <= mem_r;
`ifdef HAZARD_WB_BYPASS_EN
      wb2_r <= wb_r;
`endif
    end
  end

  // Registered forwarding selects, valid for the whole EX cycle of the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_sel_r <= 2'd0;
      fwd_b_sel_r <= 2'd0;
    end else begin
      fwd_a_sel_r <= fwd_a_nxt_s;
      fwd_b_sel_r <= fwd_b_nxt_s;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= {CNT_WIDTH{1'b0}};
    end else if (stall_s && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_WIDTH'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall       = stall_s;
  assign fwd_a_sel   = fwd_a_sel_r;
  assign fwd_b_sel   = fwd_b_sel_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed pipeline scenarios plus randomized traffic
// compared against an instruction-history reference model.
module tb_hazard_fwd_unit;

  localparam int RB = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst_s;
  logic          id_valid_s;
  logic [RB-1:0] id_rs_s;
  logic [RB-1:0] id_rt_s;
  logic          id_rs_used_s;
  logic          id_rt_used_s;
  logic [RB-1:0] id_rd_s;
  logic          id_reg_write_s;
  logic          id_mem_read_s;
  logic          flush_s;
  logic          stall_s;
  logic [1:0]    fwd_a_sel_s;
  logic [1:0]    fwd_b_sel_s;
  logic [CW-1:0] stall_count_s;

  hazard_fwd_unit #(.REG_BITS(RB), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst_s),
    .id_valid     (id_valid_s),
    .id_rs        (id_rs_s),
    .id_rt        (id_rt_s),
    .id_rs_used   (id_rs_used_s),
    .id_rt_used   (id_rt_used_s),
    .id_rd        (id_rd_s),
    .id_reg_write (id_reg_write_s),
    .id_mem_read  (id_mem_read_s),
    .flush        (flush_s),
    .stall        (stall_s),
    .fwd_a_sel    (fwd_a_sel_s),
    .fwd_b_sel    (fwd_b_sel_s),
    .stall_count  (stall_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of instructions that entered EX, most recent first.
  typedef struct {
    logic          valid;
    logic [RB-1:0] dest;
    logic          rw;
    logic          load;
  } instr_t;

  instr_t history[$];
  int     tests_run    = 0;
  int     tests_failed = 0;
  int     m_cnt        = 0;
  logic [1:0] m_a      = 2'd0;
  logic [1:0] m_b      = 2'd0;
  logic   last_stall   = 1'b0;
  logic [1:0] wb_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction d slots back from the one now in EX (0 = EX, 1 = MEM, 2 = WB).
  function automatic instr_t older(input int d);
    instr_t none;
    none = '{valid: 1'b0, dest: 5'd0, rw: 1'b0, load: 1'b0};
    if (d < history.size()) return history[d];
    return none;
  endfunction

  function automatic logic produces(input instr_t i, input logic [RB-1:0] r);
    return i.valid && i.rw && (i.dest == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] expect_sel(input logic [RB-1:0] src, input logic used);
    if (!used) return 2'd0;
    if (produces(older(0), src)) return 2'd1;
    if (produces(older(1), src)) return 2'd2;
`ifdef HAZARD_WB_BYPASS_EN
    if (produces(older(2), src)) return 2'd3;
`endif
    return 2'd0;
  endfunction

  // Drives one ID-stage cycle, checks stall mid-cycle, then selects/counter after the edge.
  task automatic step(input logic v, input logic [RB-1:0] rs, input logic rsu,
                      input logic [RB-1:0] rt, input logic rtu, input logic [RB-1:0] rd,
                      input logic rw, input logic mr, input logic fl, input logic r);
    logic   exp_stall;
    instr_t ex_i;
    instr_t entering;
    id_valid_s = v; id_rs_s = rs; id_rs_used_s = rsu; id_rt_s = rt; id_rt_used_s = rtu;
    id_rd_s = rd; id_reg_write_s = rw; id_mem_read_s = mr; flush_s = fl; rst_s = r;
    @(negedge clk);
    ex_i = older(0);
    exp_stall = v && !fl && ex_i.load &&
                ((rsu && produces(ex_i, rs)) || (rtu && produces(ex_i, rt)));
    check_val("stall", {31'd0, stall_s}, {31'd0, exp_stall});
    @(posedge clk);
    if (r) begin
      history.delete();
      m_a = 2'd0; m_b = 2'd0; m_cnt = 0;
      last_stall = 1'b0;
    end else begin
      if (exp_stall && m_cnt < (1 << CW) - 1) m_cnt++;
      if (v && !fl && !exp_stall) begin
        m_a = expect_sel(rs, rsu);
        m_b = expect_sel(rt, rtu);
        entering = '{valid: 1'b1, dest: rd, rw: rw, load: mr};
      end else begin
        m_a = 2'd0; m_b = 2'd0;
        entering = '{valid: 1'b0, dest: 5'd0, rw: 1'b0, load: 1'b0};
      end
      history.push_front(entering);
      if (history.size() > 3) void'(history.pop_back());
      last_stall = exp_stall;
    end
    #1;
    check_val("fwd_a_sel", {30'd0, fwd_a_sel_s}, {30'd0, m_a});
    check_val("fwd_b_sel", {30'd0, fwd_b_sel_s}, {30'd0, m_b});
    check_val("stall_count", {28'd0, stall_count_s}, m_cnt);
  endtask

  task automatic do_reset();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic          r_v, r_rsu, r_rtu, r_rw, r_mr, r_fl, r_rst;
  logic [RB-1:0] r_rs, r_rt, r_rd;

  initial begin
    rst_s = 1'b1; id_valid_s = 1'b0; id_rs_s = 5'd0; id_rt_s = 5'd0; id_rs_used_s = 1'b0;
    id_rt_used_s = 1'b0; id_rd_s = 5'd0; id_reg_write_s = 1'b0; id_mem_read_s = 1'b0;
    flush_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and first cycle after reset.
    do_reset();
    check_val("reset_cnt", {28'd0, stall_count_s}, 32'd0);
    nop();

    // Back-to-back ALU dependency forwards from EX/MEM.
    step(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("alu_fwd_a", {30'd0, fwd_a_sel_s}, 32'd1);

    // Load-use: one stall cycle, then both operands from MEM/WB.
    do_reset();
    step(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("lu_cnt1", {28'd0, stall_count_s}, 32'd1);
    step(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("lu_fwd_a", {30'd0, fwd_a_sel_s}, 32'd2);
    check_val("lu_fwd_b", {30'd0, fwd_b_sel_s}, 32'd2);

    // Producer three slots ahead reaches the WB bypass path.
    do_reset();
    step(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    nop();
    step(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_WB_BYPASS_EN
    wb_exp = 2'd3;
`else
    wb_exp = 2'd0;
`endif
    check_val("wb_fwd_b", {30'd0, fwd_b_sel_s}, {30'd0, wb_exp});

    // Register 0 never forwards; nearest of two producers wins.
    do_reset();
    step(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("r0_fwd_a", {30'd0, fwd_a_sel_s}, 32'd0);
    step(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("nearest_a", {30'd0, fwd_a_sel_s}, 32'd1);

    // Flush beats load-use stall; reset during a stall cancels it.
    do_reset();
    step(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("flush_cnt", {28'd0, stall_count_s}, 32'd0);
    step(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("rst_cnt", {28'd0, stall_count_s}, 32'd0);
    step(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rst_fwd_a", {30'd0, fwd_a_sel_s}, 32'd0);

    // Randomized traffic; a stalled ID instruction is held until it issues or is flushed.
    do_reset();
    r_v = 1'b0; r_rs = 5'd0; r_rt = 5'd0; r_rd = 5'd0;
    r_rsu = 1'b0; r_rtu = 1'b0; r_rw = 1'b0; r_mr = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!last_stall) begin
        r_v   = ($urandom_range(0, 7) != 0);
        r_rs  = 5'($urandom_range(0, 7));
        r_rt  = 5'($urandom_range(0, 7));
        r_rd  = 5'($urandom_range(0, 7));
        r_rsu = ($urandom_range(0, 3) != 0);
        r_rtu = ($urandom_range(0, 1) != 0);
        r_rw  = ($urandom_range(0, 4) != 0);
        r_mr  = ($urandom_range(0, 2) == 0);
      end
      r_fl  = ($urandom_range(0, 9) == 0);
      r_rst = ($urandom_range(0, 199) == 0);
      step(r_v, r_rs, r_rsu, r_rt, r_rtu, r_rd, r_rw, r_mr, r_fl, r_rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter: REG_BITS, default 5, register-index width.
REQ-002 Parameter: CNT_WIDTH, default 16, stall-counter width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: id_valid  input  1  ID-stage instruction is real (not a bubble).
REQ-006 Port: id_rs, id_rt  input  REG_BITS each  ID source register indices.
REQ-007 Port: id_rs_used, id_rt_used  input  1 each  source actually read.
REQ-008 Port: id_rd  input  REG_BITS  ID destination index.
REQ-009 Port: id_reg_write  input  1  ID instruction writes id_rd.
REQ-010 Port: id_mem_read  input  1  ID instruction is a load.
REQ-011 Port: flush  input  1  kill the ID instruction (branch/jump redirect).
REQ-012 Port: stall  output  1  combinational; hold PC and IF/ID, bubble into EX.
REQ-013 Port: fwd_a_sel, fwd_b_sel  output  2 each  registered; drive 4:1 operand mux selects in EX (0 regfile, 1 EX/MEM, 2 MEM/WB, 3 WB bypass).
REQ-014 Port: stall_count  output  CNT_WIDTH  saturating count of stall cycles.

Function
REQ-015 Unit SHALL keep four stage records EX, MEM, WB, WB2, each {valid, dest, reg_write, mem_read}.
REQ-016 Record "writes r" SHALL mean valid & reg_write & dest==r & r!=0; register 0 never matches.
REQ-017 stall SHALL be 1 when id_valid & !flush & EX writes rs (id_rs_used) or rt (id_rt_used) & EX.mem_read; else 0.
REQ-018 Each edge, not stall: EX<=ID record (valid=id_valid&!flush), MEM<=EX, WB<=MEM, WB2<=WB.
REQ-019 Each edge, stall: EX<=bubble (valid=0), MEM<=EX, WB<=MEM, WB2<=WB; ID inputs held upstream.
REQ-020 fwd_x_sel SHALL register, per used source, priority nearest-first: EX writes src -> 1; else MEM writes src -> 2; else WB writes src -> 3 (REQ-030); else 0.
REQ-021 fwd_x_sel SHALL be 0 when source unused, src==0, stall, flush or !id_valid.
REQ-022 Latency: sel registered on the edge ID->EX, valid for the whole following EX cycle.
REQ-023 Load in EX matched by ID SHALL stall exactly one cycle; next cycle load is in MEM, stall=0, sel=2.
REQ-024 flush and stall asserted together: flush wins; stall=0, bubble into EX.
REQ-025 stall_count SHALL increment on each edge with stall=1, saturating at all-ones.

Reset
REQ-026 rst=1 at an edge SHALL clear all record valids, fwd_a_sel=fwd_b_sel=0, stall_count=0.
REQ-027 stall SHALL read 0 while all records are invalid (first cycle after reset).
REQ-028 rst mid-stall SHALL cancel the stall; no record survives.
REQ-029 rst SHALL take precedence over flush and stall.

Configuration
REQ-030 Macro HAZARD_WB_BYPASS_EN defined: WB-stage match yields sel 3 (regfile not write-through).
REQ-031 Macro undefined: sel 3 never produced; WB match yields 0; WB2 record may be optimised away.

Verification
REQ-032 add $3 ; add $4,$3,$5 back-to-back -> stall=0, fwd_a_sel=1 in consumer EX cycle.
REQ-033 lw $8 ; add $9,$8,$8 -> stall=1 one cycle, stall_count 0->1, then fwd_a_sel=fwd_b_sel=2.
REQ-034 add $2 ; nop ; nop ; sub $6,$1,$2 -> fwd_b_sel=3 with macro, 0 without.
REQ-035 add $0,... ; add $7,$0,$0 -> fwd sels 0, stall 0; add $3 ; add $3 ; use $3 -> sel=1 (nearest wins).
REQ-036 lw $8 then add $9,$8 with flush=1 -> stall=0, EX bubble; rst during stall -> sels 0, stall_count 0.
